mul16_rr_arbiter: RTL and testbench

- Shares one combinational array16 16x16 unsigned multiplier among NREQ requesters.
- Round-robin arbitration, registered operands, registered product.
- Per-requester valid/ready request side; single valid/ready response side tagged with the requester index.
- Sits between the requesting datapath engines and the multiplier, and is the only block that drives the multiplier operands.

---
 rtl/mul16_rr_arbiter_if.sv | 26 ++
 rtl/mul16_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_mul16_rr_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul16_rr_arbiter_if.sv
// Request/response bundle between the requesting engines and the shared
// 16x16 multiplier arbiter. The arbiter takes the slave view; the engines
// and the product consumer together take the master view.
interface mul16_rr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [16*NREQ-1:0] req_a;
   logic [16*NREQ-1:0] req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [31:0]        rsp_p;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_p
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_p
   );
endinterface

// File: rtl/mul16_rr_arbiter.sv
// Round-robin arbiter sharing one combinational 16x16 unsigned array
// multiplier among NREQ requesters. A grant in IDLE latches the winner's
// operands, MUL registers the product, RESP holds it until the consumer
// accepts it. One product per three clocks at best.
module mul16_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   mul16_rr_arbiter_if.slave bus,
   output logic              busy
);
   localparam int DATA_W = 16;
   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    rr_ptr, rr_ptr_d;
   logic              grant_vld;
   logic [IDW-1:0]    grant_idx;
   logic [NREQ-1:0]   grant_oh;

   logic [DATA_W-1:0] a_arr [NREQ];
   logic [DATA_W-1:0] b_arr [NREQ];

   logic [DATA_W-1:0] op_a_p0, op_b_p0;
   logic [IDW-1:0]    id_p0;
   logic [PROD_W-1:0] prod_p1;
   logic [IDW-1:0]    id_p1;
   logic              vld_p1;

   // Exact unsigned shift-and-add array product; a full 32-bit result
   // cannot overflow, so no rounding or saturation is ever applied.
   function automatic logic [PROD_W-1:0] array16(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic [PROD_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (b[i]) acc = acc + ({{DATA_W{1'b0}}, a} << i);
      end
      return acc;
   endfunction

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = bus.req_a[DATA_W*gi +: DATA_W];
      assign b_arr[gi] = bus.req_b[DATA_W*gi +: DATA_W];
   end

   // Find the first valid requester at or above rr_ptr, wrapping modulo NREQ.
   always_comb begin
      int             idx;
      logic [IDW-1:0] idx_w;
      idx       = 0;
      idx_w     = '0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_w = IDW'(idx);
         if (!grant_vld && bus.req_valid[idx_w]) begin
            grant_vld = 1'b1;
            grant_idx = idx_w;
         end
      end
   end

   // Next-state, grant and pointer-advance logic; grants only happen in IDLE.
   always_comb begin
      int nxt;
      state_d  = state_q;
      rr_ptr_d = rr_ptr;
      grant_oh = '0;
      nxt      = 0;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               grant_oh = NREQ'(1) << grant_idx;
               nxt      = int'(grant_idx) + 1;
               if (nxt >= NREQ) nxt = 0;
               rr_ptr_d = IDW'(nxt);
               state_d  = MUL;
            end
         end
         MUL:     state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control state: FSM and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_ptr  <= '0;
      end else begin
         state_q <= state_d;
         rr_ptr  <= rr_ptr_d;
      end
   end

   // Stage p0: latch the winner's operands and index on the grant edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_p0 <= '0;
         op_b_p0 <= '0;
         id_p0   <= '0;
      end else if (state_q == IDLE && grant_vld) begin
         op_a_p0 <= a_arr[grant_idx];
         op_b_p0 <= b_arr[grant_idx];
         id_p0   <= grant_idx;
      end
   end

   // Stage p1: register the product in MUL and hold it until accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_p1 <= '0;
         id_p1   <= '0;
         vld_p1  <= 1'b0;
      end else if (state_q == MUL) begin
         prod_p1 <= array16(op_a_p0, op_b_p0);
         id_p1   <= id_p0;
         vld_p1  <= 1'b1;
      end else if (state_q == RESP && bus.rsp_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign bus.req_ready = grant_oh;
   assign bus.rsp_valid = vld_p1;
   assign bus.rsp_p     = prod_p1;
   assign bus.rsp_id    = id_p1;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mul16_rr_arbiter.sv
// Scenario bench for mul16_rr_arbiter: expected responses are queued when a
// request is driven and popped when the arbiter presents a product.
`timescale 1ns/1ps
module tb_mul16_rr_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   typedef struct {
      logic [IDW-1:0] id;
      logic [31:0]    p;
   } exp_t;

   logic clk;
   logic rst_n;
   logic busy;
   int   vec_cnt;
   int   err_cnt;
   exp_t sb[$];

   mul16_rr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   mul16_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b);
      bus.req_a[16*r +: 16] = a;
      bus.req_b[16*r +: 16] = b;
   endtask

   task automatic push_exp(input int id, input logic [31:0] p);
      exp_t e;
      e.id = IDW'(id);
      e.p  = p;
      sb.push_back(e);
   endtask

   // Waits (bounded) for rsp_valid, records the response, then handshakes.
   task automatic collect(output bit got, output logic [IDW-1:0] id, output logic [31:0] p);
      got = 1'b0;
      id  = 'x;
      p   = 'x;
      for (int c = 0; c < 12 && !got; c++) begin
         if (bus.rsp_valid === 1'b1) begin
            got = 1'b1;
            id  = bus.rsp_id;
            p   = bus.rsp_p;
         end else begin
            step();
         end
      end
      if (got) begin
         bus.rsp_ready = 1'b1;
         step();
         bus.rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.rsp_ready = 1'b0;
      step();
      step();
      vec_cnt++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_ctrl: rsp_valid=%b busy=%b expected 0 0", bus.rsp_valid, busy);
      end
      vec_cnt++;
      if (bus.req_ready !== 4'b0000) begin
         err_cnt++;
         $display("FAIL reset_ready: req_ready=%b expected 0000", bus.req_ready);
      end
      vec_cnt++;
      if (bus.rsp_p !== 32'h0 || bus.rsp_id !== 2'd0) begin
         err_cnt++;
         $display("FAIL reset_data: rsp_p=%h rsp_id=%0d expected 0 0", bus.rsp_p, bus.rsp_id);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_round_robin();
      exp_t       e;
      logic [3:0] exp_oh;
      for (int r = 0; r < NREQ; r++) set_req(r, 16'(r + 1), 16'h0100);
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      for (int g = 0; g < 5; g++) begin
         settle();
         exp_oh = 4'(1 << (g % NREQ));
         vec_cnt++;
         if (bus.req_ready !== exp_oh) begin
            err_cnt++;
            $display("FAIL rr_grant%0d: req_ready=%b expected %b", g, bus.req_ready, exp_oh);
         end
         push_exp(g % NREQ, 32'((g % NREQ + 1) * 256));
         step();
         if (g == 0) begin
            vec_cnt++;
            if (bus.req_ready !== 4'b0000 || busy !== 1'b1) begin
               err_cnt++;
               $display("FAIL rr_mul_state: req_ready=%b busy=%b expected 0000 1", bus.req_ready, busy);
            end
         end
         step();
         e = sb.pop_front();
         vec_cnt++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e.id || bus.rsp_p !== e.p) begin
            err_cnt++;
            $display("FAIL rr_rsp%0d: valid=%b id=%0d p=%h expected 1 %0d %h",
                     g, bus.rsp_valid, bus.rsp_id, bus.rsp_p, e.id, e.p);
         end
         step();
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_single();
      bit             got;
      logic [IDW-1:0] id;
      logic [31:0]    p;
      exp_t           e;
      set_req(0, 16'h1234, 16'h5678);
      bus.req_valid = 4'b0001;
      settle();
      vec_cnt++;
      if (bus.req_ready !== 4'b0001 || busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_grant: req_ready=%b busy=%b expected 0001 0", bus.req_ready, busy);
      end
      push_exp(0, 32'h06260060);
      step();
      bus.req_valid = '0;
      settle();
      vec_cnt++;
      if (bus.req_ready !== 4'b0000 || busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_mul: req_ready=%b busy=%b rsp_valid=%b expected 0000 1 0",
                  bus.req_ready, busy, bus.rsp_valid);
      end
      step();
      vec_cnt++;
      if (bus.rsp_valid !== 1'b1) begin
         err_cnt++;
         $display("FAIL single_latency: rsp_valid=%b two clocks after grant, expected 1", bus.rsp_valid);
      end
      collect(got, id, p);
      e = sb.pop_front();
      vec_cnt++;
      if (!got || id !== e.id || p !== e.p) begin
         err_cnt++;
         $display("FAIL single_rsp: got=%0d id=%0d p=%h expected id=%0d p=%h", got, id, p, e.id, e.p);
      end
      vec_cnt++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_done: rsp_valid=%b busy=%b expected 0 0", bus.rsp_valid, busy);
      end
   endtask

   task automatic test_corners();
      logic [15:0]    ta [4] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000};
      logic [15:0]    tb [4] = '{16'hFFFF, 16'h0001, 16'h0002, 16'hABCD};
      logic [31:0]    tp [4] = '{32'hFFFE0001, 32'h0000FFFF, 32'h00010000, 32'h00000000};
      bit             got;
      logic [IDW-1:0] id;
      logic [31:0]    p;
      exp_t           e;
      for (int k = 0; k < 4; k++) begin
         set_req(2, ta[k], tb[k]);
         bus.req_valid = 4'b0100;
         push_exp(2, tp[k]);
         step();
         bus.req_valid = '0;
         collect(got, id, p);
         e = sb.pop_front();
         vec_cnt++;
         if (!got || id !== e.id || p !== e.p) begin
            err_cnt++;
            $display("FAIL corner%0d: got=%0d id=%0d p=%h expected id=%0d p=%h", k, got, id, p, e.id, e.p);
         end
      end
   endtask

   task automatic test_backpressure();
      bit             got;
      logic [IDW-1:0] id;
      logic [31:0]    p;
      exp_t           e;
      set_req(0, 16'h00AB, 16'h0100);
      set_req(1, 16'h0002, 16'h0003);
      bus.req_valid = 4'b0001;
      push_exp(0, 32'h0000AB00);
      step();
      bus.req_valid = 4'b1111;
      step();
      for (int c = 0; c < 5; c++) begin
         vec_cnt++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== sb[0].id || bus.rsp_p !== sb[0].p ||
             bus.req_ready !== 4'b0000) begin
            err_cnt++;
            $display("FAIL bp_hold%0d: valid=%b id=%0d p=%h ready=%b expected 1 %0d %h 0000",
                     c, bus.rsp_valid, bus.rsp_id, bus.rsp_p, bus.req_ready, sb[0].id, sb[0].p);
         end
         step();
      end
      bus.rsp_ready = 1'b1;
      settle();
      vec_cnt++;
      if (bus.req_ready !== 4'b0000) begin
         err_cnt++;
         $display("FAIL bp_handshake_ready: req_ready=%b expected 0000", bus.req_ready);
      end
      e = sb.pop_front();
      step();
      bus.rsp_ready = 1'b0;
      settle();
      vec_cnt++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 4'b0010) begin
         err_cnt++;
         $display("FAIL bp_release: valid=%b busy=%b ready=%b expected 0 0 0010",
                  bus.rsp_valid, busy, bus.req_ready);
      end
      vec_cnt++;
      if (bus.rsp_p !== e.p || bus.rsp_id !== e.id) begin
         err_cnt++;
         $display("FAIL bp_keep: p=%h id=%0d expected %h %0d", bus.rsp_p, bus.rsp_id, e.p, e.id);
      end
      push_exp(1, 32'h6);
      step();
      bus.req_valid = '0;
      vec_cnt++;
      if (busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL bp_next_grant: busy=%b expected 1", busy);
      end
      collect(got, id, p);
      e = sb.pop_front();
      vec_cnt++;
      if (!got || id !== e.id || p !== e.p) begin
         err_cnt++;
         $display("FAIL bp_next_rsp: got=%0d id=%0d p=%h expected id=%0d p=%h", got, id, p, e.id, e.p);
      end
   endtask

   task automatic test_wrap_skip();
      bit             got;
      logic [IDW-1:0] id;
      logic [31:0]    p;
      exp_t           e;
      set_req(2, 16'd5, 16'd7);
      bus.req_valid = 4'b0100;
      push_exp(2, 32'd35);
      step();
      bus.req_valid = '0;
      collect(got, id, p);
      e = sb.pop_front();
      vec_cnt++;
      if (!got || id !== e.id || p !== e.p) begin
         err_cnt++;
         $display("FAIL wrap_setup: got=%0d id=%0d p=%h expected id=%0d p=%h", got, id, p, e.id, e.p);
      end
      set_req(1, 16'h0010, 16'h0010);
      bus.req_valid = 4'b0110;
      settle();
      vec_cnt++;
      if (bus.req_ready !== 4'b0010) begin
         err_cnt++;
         $display("FAIL wrap_grant: req_ready=%b expected 0010", bus.req_ready);
      end
      push_exp(1, 32'h100);
      step();
      bus.req_valid = '0;
      collect(got, id, p);
      e = sb.pop_front();
      vec_cnt++;
      if (!got || id !== e.id || p !== e.p) begin
         err_cnt++;
         $display("FAIL wrap_rsp: got=%0d id=%0d p=%h expected id=%0d p=%h", got, id, p, e.id, e.p);
      end
      bus.req_valid = 4'b1111;
      settle();
      vec_cnt++;
      if (bus.req_ready !== 4'b0100) begin
         err_cnt++;
         $display("FAIL wrap_ptr: req_ready=%b expected 0100", bus.req_ready);
      end
      bus.req_valid = '0;
      step();
   endtask

   task automatic test_reset_mid_mul();
      bit             got;
      logic [IDW-1:0] id;
      logic [31:0]    p;
      exp_t           e;
      int             stray;
      set_req(1, 16'h0010, 16'h0010);
      bus.req_valid = 4'b0010;
      step();
      bus.req_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
         err_cnt++;
         $display("FAIL rst_mid: valid=%b busy=%b ready=%b expected 0 0 0000",
                  bus.rsp_valid, busy, bus.req_ready);
      end
      step();
      rst_n = 1'b1;
      stray = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (bus.rsp_valid !== 1'b0) stray++;
      end
      vec_cnt++;
      if (stray != 0) begin
         err_cnt++;
         $display("FAIL rst_no_rsp: rsp_valid seen %0d cycles expected 0", stray);
      end
      set_req(0, 16'h00AB, 16'h0100);
      bus.req_valid = 4'b1111;
      settle();
      vec_cnt++;
      if (bus.req_ready !== 4'b0001) begin
         err_cnt++;
         $display("FAIL rst_ptr: req_ready=%b expected 0001", bus.req_ready);
      end
      push_exp(0, 32'h0000AB00);
      step();
      bus.req_valid = '0;
      collect(got, id, p);
      e = sb.pop_front();
      vec_cnt++;
      if (!got || id !== e.id || p !== e.p) begin
         err_cnt++;
         $display("FAIL rst_after_rsp: got=%0d id=%0d p=%h expected id=%0d p=%h", got, id, p, e.id, e.p);
      end
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      test_reset();
      test_round_robin();
      test_single();
      test_corners();
      test_backpressure();
      test_wrap_skip();
      test_reset_mid_mul();
      vec_cnt++;
      if (sb.size() != 0) begin
         err_cnt++;
         $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
